mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have ports: Op  input  6  instruction opcode; Funct  input  6  R-type function field.
REQ-004 SHALL have ports: Zero  input  1  ALU equality flag; IMemRdy  input  1  instruction fetch done; DMemRdy  input  1  data access done.
REQ-005 SHALL have ports: PCWr  output  1  PC load; NPCOp  output  2  next-PC select (0 PC+4, 1 branch, 2 j/jal target, 3 jr register).
REQ-006 SHALL have ports: IRWr  output  1  IR load; EXTOp  output  2  immediate extender mode (0 sign, 1 zero, 2 upper-half).
REQ-007 SHALL have ports: ALUSrc  output  1  1 = extended immediate; ALUOp  output  3  (0 add, 1 sub, 2 or, 3 pass B).
REQ-008 SHALL have ports: RegWr  output  1; RegDst  output  2  (0 rt, 1 rd, 2 $31); WDSel  output  2  (0 ALU, 1 memory, 2 PC link).
REQ-009 SHALL have ports: MemWr  output  1; Illegal  output  1  one-cycle unknown-instruction pulse; State  output  3  current state.

Function
REQ-010 SHALL decode: R-type Op=000000 with Funct addu=100001, subu=100011, jr=001000; ori=001101; lw=100011; sw=101011; beq=000100; lui=001111; j=000010; jal=000011.
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 go to FETCH on the next edge with all writes low.
REQ-012 FETCH: IRWr=1 and PCWr=1 with NPCOp=0 only when IMemRdy=1, then DECODE; else hold FETCH with no writes.
REQ-013 DECODE: EXTOp driven from Op (lw/sw/beq 0, ori 1, lui 2, others 0); EXTOp holds this value through EXEC, MEM and WB of the same instruction.
REQ-014 DECODE, j: PCWr=1, NPCOp=2, then FETCH; jal: additionally RegWr=1, RegDst=2, WDSel=2.
REQ-015 DECODE, unknown Op/Funct: Illegal=1 for that cycle, no write strobes, then FETCH.
REQ-016 DECODE, all other decoded instructions: go to EXEC.
REQ-017 EXEC, beq: ALUOp=1, ALUSrc=0, PCWr=Zero (combinational), NPCOp=1, then FETCH.
REQ-018 EXEC, jr: PCWr=1, NPCOp=3, then FETCH.
REQ-019 EXEC, ALU ops: addu ALUOp=0, subu ALUOp=1, both with ALUSrc=0; ori ALUOp=2 with ALUSrc=1; lui ALUOp=3 with ALUSrc=1; then WB.
REQ-020 EXEC, lw/sw: ALUOp=0, ALUSrc=1, then MEM.
REQ-021 MEM, sw: MemWr=1 every cycle until DMemRdy=1, then FETCH; lw: wait for DMemRdy=1, then WB.
REQ-022 WB: RegWr=1 for one cycle; RegDst=1 for R-type, 0 otherwise; WDSel=1 for lw, 0 otherwise; then FETCH.
REQ-023 Inactive control outputs SHALL be 0 in every state; PCWr, IRWr, RegWr and MemWr SHALL never be high outside the cases above.
REQ-024 Each instruction SHALL produce at most one PCWr in FETCH and one in DECODE or EXEC, and exactly one RegWr if it writes a register.
REQ-025 Cycle counts with ready inputs tied high: j/jal 2, beq/jr 3, sw 4, addu/subu/ori/lui 4, lw 5.
REQ-026 Op and Funct SHALL be sampled from the IR every cycle; the IR is stable from DECODE onward because IRWr is high only in FETCH.

Reset
REQ-027 When reset=0, State SHALL go to FETCH immediately, without waiting for clk, and all strobes, EXTOp, NPCOp, ALUOp, RegDst and WDSel SHALL be 0.
REQ-028 Reset asserted mid-instruction, including during a MEM wait, SHALL abandon the instruction; no write strobe SHALL be issued after reset asserts.
REQ-029 After reset deasserts, the first action SHALL be a fetch in FETCH on the next rising edge at which IMemRdy=1.

Verification
REQ-030 ori, IMemRdy=DMemRdy=1 -> states 0,1,2,4; EXTOp=1 from DECODE through WB; ALUSrc=1 and ALUOp=2 in EXEC; RegWr=1 with RegDst=0 in WB only.
REQ-031 lw, DMemRdy held low 3 cycles -> MEM held 4 cycles; then WB with WDSel=1, RegWr=1; 8 cycles total; EXTOp=0.
REQ-032 beq with Zero=0, then with Zero=1 -> PCWr=0, then PCWr=1 with NPCOp=1, in EXEC; both return to FETCH after 3 cycles.
REQ-033 lui -> EXTOp=2 and ALUOp=3 in EXEC; jal -> in DECODE, PCWr=1, NPCOp=2, RegWr=1, RegDst=2, WDSel=2.
REQ-034 Op=111111 -> Illegal pulses exactly one cycle in DECODE, then FETCH, with no strobes.
REQ-035 reset driven to 0 mid-cycle during an sw MEM wait -> State=0 and MemWr=0 before the next clk edge; after release, the first fetch occurs on the first edge with IMemRdy=1.

Source files
------------

// File: rtl/mc_ctrl.sv
// ============================================================================
// mc_ctrl : multi-cycle MIPS-subset controller (FETCH/DECODE/EXEC/MEM/WB)
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       IMemRdy,
  input  logic       DMemRdy,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic       IRWr,
  output logic [1:0] EXTOp,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       MemWr,
  output logic       Illegal,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t r_state;
  state_t w_next;

  logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
  logic w_legal;
  logic [1:0] w_ext;

  assign w_rtype = (Op == OP_RTYPE);
  assign w_addu  = w_rtype && (Funct == FN_ADDU);
  assign w_subu  = w_rtype && (Funct == FN_SUBU);
  assign w_jr    = w_rtype && (Funct == FN_JR);
  assign w_ori   = (Op == OP_ORI);
  assign w_lw    = (Op == OP_LW);
  assign w_sw    = (Op == OP_SW);
  assign w_beq   = (Op == OP_BEQ);
  assign w_lui   = (Op == OP_LUI);
  assign w_j     = (Op == OP_J);
  assign w_jal   = (Op == OP_JAL);
  assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lw | w_sw | w_beq | w_lui | w_j | w_jal;
  assign w_ext   = w_ori ? 2'd1 : (w_lui ? 2'd2 : 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  assign State = r_state;

  always_comb begin
    w_next  = S_FETCH;
    PCWr    = 1'b0;
    NPCOp   = 2'd0;
    IRWr    = 1'b0;
    EXTOp   = 2'd0;
    ALUSrc  = 1'b0;
    ALUOp   = 3'd0;
    RegWr   = 1'b0;
    RegDst  = 2'd0;
    WDSel   = 2'd0;
    MemWr   = 1'b0;
    Illegal = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (IMemRdy) begin
          IRWr   = 1'b1;
          PCWr   = 1'b1;
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end

      S_DECODE: begin
        EXTOp = w_ext;
        if (w_j || w_jal) begin
          PCWr  = 1'b1;
          NPCOp = 2'd2;
          if (w_jal) begin
            RegWr  = 1'b1;
            RegDst = 2'd2;
            WDSel  = 2'd2;
          end
          w_next = S_FETCH;
        end else if (!w_legal) begin
          Illegal = 1'b1;
          w_next  = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end

      S_EXEC: begin
        EXTOp = w_ext;
        if (w_beq) begin
          ALUOp = 3'd1;
          PCWr  = Zero;
          NPCOp = 2'd1;
        end else if (w_jr) begin
          PCWr  = 1'b1;
          NPCOp = 2'd3;
        end else if (w_addu || w_subu) begin
          ALUOp  = w_subu ? 3'd1 : 3'd0;
          w_next = S_WB;
        end else if (w_ori || w_lui) begin
          ALUOp  = w_lui ? 3'd3 : 3'd2;
          ALUSrc = 1'b1;
          w_next = S_WB;
        end else if (w_lw || w_sw) begin
          ALUSrc = 1'b1;
          w_next = S_MEM;
        end
      end

      S_MEM: begin
        EXTOp = w_ext;
        if (w_sw) begin
          MemWr  = 1'b1;
          w_next = DMemRdy ? S_FETCH : S_MEM;
        end else if (w_lw) begin
          w_next = DMemRdy ? S_WB : S_MEM;
        end
      end

      S_WB: begin
        EXTOp  = w_ext;
        RegWr  = 1'b1;
        RegDst = w_rtype ? 2'd1 : 2'd0;
        WDSel  = w_lw ? 2'd1 : 2'd0;
      end

      default: w_next = S_FETCH;
    endcase

    // Reset overrides everything so no strobe escapes between reset and the next edge
    if (!reset) begin
      w_next  = S_FETCH;
      PCWr    = 1'b0;
      NPCOp   = 2'd0;
      IRWr    = 1'b0;
      EXTOp   = 2'd0;
      ALUSrc  = 1'b0;
      ALUOp   = 3'd0;
      RegWr   = 1'b0;
      RegDst  = 2'd0;
      WDSel   = 2'd0;
      MemWr   = 1'b0;
      Illegal = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// tb_mc_ctrl : randomized instruction stream checked against a per-instruction
// expected-cycle plan. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero, IMemRdy, DMemRdy;
  logic       PCWr, IRWr, ALUSrc, RegWr, MemWr, Illegal;
  logic [1:0] NPCOp, EXTOp, RegDst, WDSel;
  logic [2:0] ALUOp, State;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IMemRdy(IMemRdy), .DMemRdy(DMemRdy), .PCWr(PCWr), .NPCOp(NPCOp),
    .IRWr(IRWr), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .RegWr(RegWr), .RegDst(RegDst), .WDSel(WDSel), .MemWr(MemWr),
    .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  typedef struct {
    bit [5:0] op, funct;
    bit       imem, dmem, zero;
    bit       pcwr;
    bit [1:0] npc;
    bit       irwr;
    bit [1:0] ext;
    bit       alusrc;
    bit [2:0] aluop;
    bit       regwr;
    bit [1:0] regdst, wdsel;
    bit       memwr, ill;
    bit [2:0] st;
  } rec_t;

  rec_t plan_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pack_exp(input rec_t r);
    return {12'd0, r.pcwr, r.npc, r.irwr, r.ext, r.alusrc, r.aluop,
            r.regwr, r.regdst, r.wdsel, r.memwr, r.ill, r.st};
  endfunction

  function automatic logic [31:0] pack_obs();
    return {12'd0, PCWr, NPCOp, IRWr, EXTOp, ALUSrc, ALUOp,
            RegWr, RegDst, WDSel, MemWr, Illegal, State};
  endfunction

  // Per-instruction expected behaviour, one record per clock cycle
  task automatic plan(input int k, input bit [5:0] op, input bit [5:0] fn,
                      input bit zero, input int fw, input int mw);
    rec_t b, r;
    bit [1:0] ext;
    ext = (k == K_ORI) ? 2'd1 : (k == K_LUI) ? 2'd2 : 2'd0;
    b = '{default: 0};
    b.op = op; b.funct = fn; b.zero = zero;
    for (int i = 0; i < fw; i++) begin
      r = b; r.dmem = 1'($urandom_range(0, 1)); plan_q.push_back(r);
    end
    r = b; r.imem = 1; r.irwr = 1; r.pcwr = 1; plan_q.push_back(r);
    r = b; r.st = 1; r.ext = ext; r.imem = 1'($urandom_range(0, 1)); r.dmem = 1'($urandom_range(0, 1));
    if (k == K_J || k == K_JAL) begin
      r.pcwr = 1; r.npc = 2;
      if (k == K_JAL) begin r.regwr = 1; r.regdst = 2; r.wdsel = 2; end
      plan_q.push_back(r);
      return;
    end
    if (k == K_ILL) begin r.ill = 1; plan_q.push_back(r); return; end
    plan_q.push_back(r);
    r = b; r.st = 2; r.ext = ext; r.imem = 1'($urandom_range(0, 1)); r.dmem = 1'($urandom_range(0, 1));
    case (k)
      K_BEQ:  begin r.aluop = 1; r.pcwr = zero; r.npc = 1; end
      K_JR:   begin r.pcwr = 1; r.npc = 3; end
      K_SUBU: r.aluop = 1;
      K_ORI:  begin r.aluop = 2; r.alusrc = 1; end
      K_LUI:  begin r.aluop = 3; r.alusrc = 1; end
      K_LW, K_SW: r.alusrc = 1;
      default: ;
    endcase
    plan_q.push_back(r);
    if (k == K_BEQ || k == K_JR) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        r = b; r.st = 3; r.ext = ext; r.memwr = (k == K_SW);
        r.imem = 1'($urandom_range(0, 1)); r.dmem = (i == mw);
        plan_q.push_back(r);
      end
      if (k == K_SW) return;
    end
    r = b; r.st = 4; r.ext = ext; r.regwr = 1;
    r.regdst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    r.wdsel  = (k == K_LW) ? 2'd1 : 2'd0;
    r.imem = 1'($urandom_range(0, 1)); r.dmem = 1'($urandom_range(0, 1));
    plan_q.push_back(r);
  endtask

  // Drive and check up to 'limit' planned cycles (all when limit < 0)
  task automatic run(input string tag, input int limit);
    rec_t r;
    int n = 0;
    while (plan_q.size() > 0 && (limit < 0 || n < limit)) begin
      r = plan_q.pop_front();
      @(negedge clk);
      Op = r.op; Funct = r.funct; IMemRdy = r.imem; DMemRdy = r.dmem; Zero = r.zero;
      #2;
      check($sformatf("%s.c%0d", tag, n), pack_obs(), pack_exp(r));
      n++;
    end
  endtask

  function automatic void enc(input int k, output bit [5:0] op, output bit [5:0] fn);
    fn = 6'($urandom_range(0, 63));
    case (k)
      K_ADDU: begin op = 6'h00; fn = 6'h21; end
      K_SUBU: begin op = 6'h00; fn = 6'h23; end
      K_JR:   begin op = 6'h00; fn = 6'h08; end
      K_ORI:  op = 6'h0D;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      K_BEQ:  op = 6'h04;
      K_LUI:  op = 6'h0F;
      K_J:    op = 6'h02;
      K_JAL:  op = 6'h03;
      default: begin
        do op = 6'($urandom_range(0, 63));
        while (op inside {6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03});
        if (op == 6'h00)
          while (fn inside {6'h21, 6'h23, 6'h08}) fn = 6'($urandom_range(0, 63));
      end
    endcase
  endfunction

  bit [5:0] op, fn;
  int k;

  initial begin
    reset = 1'b0; Op = 6'h0D; Funct = 6'h00; Zero = 1'b0; IMemRdy = 1'b1; DMemRdy = 1'b1;
    #12;
    check("reset_outputs", pack_obs(), 32'd0);
    @(negedge clk);
    reset = 1'b1; IMemRdy = 1'b0;

    // Directed: ori, lw with 3-cycle data wait, beq both ways, lui, jal, Op=111111
    enc(K_ORI, op, fn);  plan(K_ORI, op, fn, 0, 1, 0);  run("ori", -1);
    enc(K_LW, op, fn);   plan(K_LW, op, fn, 0, 0, 3);   run("lw_wait", -1);
    enc(K_BEQ, op, fn);  plan(K_BEQ, op, fn, 0, 0, 0);  run("beq_z0", -1);
    enc(K_BEQ, op, fn);  plan(K_BEQ, op, fn, 1, 0, 0);  run("beq_z1", -1);
    enc(K_LUI, op, fn);  plan(K_LUI, op, fn, 0, 0, 0);  run("lui", -1);
    enc(K_JAL, op, fn);  plan(K_JAL, op, fn, 0, 0, 0);  run("jal", -1);
    plan(K_ILL, 6'h3F, 6'h00, 0, 0, 0);                run("ill3f", -1);

    // sw held in MEM, reset asserted mid-cycle
    enc(K_SW, op, fn);   plan(K_SW, op, fn, 0, 0, 6);   run("sw_rst", 5);
    plan_q.delete();
    #1 reset = 1'b0;
    #1 check("rst_mid_mem", pack_obs(), 32'd0);
    @(negedge clk);
    IMemRdy = 1'b1;
    #2 check("rst_held", pack_obs(), 32'd0);
    @(negedge clk);
    reset = 1'b1; IMemRdy = 1'b0;
    enc(K_ADDU, op, fn); plan(K_ADDU, op, fn, 0, 2, 0); run("post_rst", -1);

    // Random instruction stream
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 10);
      enc(k, op, fn);
      plan(k, op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
      run($sformatf("rnd%0d_k%0d", i, k), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
